// File: rtl/rx_rr_arb.sv
// rx_rr_arb: round-robin arbiter granting one RX PHY at a time to a shared
// downstream FIFO. Each PHY posts a request with a one-cycle rx_start pulse.
// The arbiter grants the next eligible PHY after the last one served and holds
// the grant until that PHY signals rx_last.
//
// Optional watchdog: define RX_ARB_TIMEOUT_EN to abort grants that last
// TIMEOUT cycles. Without it timeout_pls/timeout_cnt are tied to 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   reg_flush         drop all pending requests, active grant and pointer
//   reg_mask[31:0]    per-PHY grant inhibit (1 = inhibit), sampled only in IDLE
//   rx_almost_full    downstream backpressure, blocks new grants
//   rx_start[31:0]    per-PHY frame-start pulse (posts a request)
//   rx_last[31:0]     per-PHY last-word pulse (ends the grant of that PHY)
//   rx_sel[31:0]      registered one-hot grant (0 when idle)
//   grant_id[4:0]     registered index of the granted PHY, held while idle
//   pend[31:0]        registered pending-request vector
//   timeout_pls       one-cycle pulse after a watchdog abort
//   timeout_cnt[15:0] saturating count of watchdog aborts
module rx_rr_arb #(
    parameter int unsigned NUM     = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_flush,
    input  logic [31:0] reg_mask,
    input  logic        rx_almost_full,
    input  logic [31:0] rx_start,
    input  logic [31:0] rx_last,
    output logic [31:0] rx_sel,
    output logic [4:0]  grant_id,
    output logic [31:0] pend,
    output logic        timeout_pls,
    output logic [15:0] timeout_cnt
);

    localparam int unsigned W_VEC = 32;
    localparam int unsigned W_ID  = 5;
    // Lanes that exist for this NUM; everything above stays 0.
    localparam logic [W_VEC-1:0] VALID_MASK =
        (NUM >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << NUM) - 64'd1);
    localparam logic [W_ID-1:0] PTR_RST = W_ID'(NUM - 1);

    if (NUM < 1 || NUM > 32 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("rx_rr_arb: NUM or TIMEOUT out of range");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [W_VEC-1:0]  sel_q, sel_d;
    logic [W_VEC-1:0]  pend_q, pend_d;
    logic [W_ID-1:0]   gid_q, gid_d;
    logic [W_ID-1:0]   ptr_q, ptr_d;

    logic [W_VEC-1:0]  elig;
    logic [W_VEC-1:0]  clr;
    logic              found;
    logic [W_ID-1:0]   pick;

`ifdef RX_ARB_TIMEOUT_EN
    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pls_q, pls_d;
`endif

    // Round-robin pick: first eligible lane scanning from ptr+1, wrapping at NUM.
    always_comb begin
        elig  = pend_q & ~reg_mask & VALID_MASK;
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned k = 1; k <= NUM; k++) begin
            logic [W_ID-1:0] idx;
            idx = W_ID'((32'(ptr_q) + k) % NUM);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        clr     = '0;
`ifdef RX_ARB_TIMEOUT_EN
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        pls_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_almost_full && found) begin
                    sel_d   = W_VEC'(1) << pick;
                    clr     = W_VEC'(1) << pick;
                    gid_d   = pick;
                    state_d = S_GRANT;
`ifdef RX_ARB_TIMEOUT_EN
                    tmr_d   = '0;
`endif
                end
            end
            S_GRANT: begin
                // rx_last wins over a watchdog expiry in the same cycle.
                if (rx_last[gid_q]) begin
                    sel_d   = '0;
                    ptr_d   = gid_q;
                    state_d = S_IDLE;
                end
`ifdef RX_ARB_TIMEOUT_EN
                else if (tmr_q == TMR_LAST) begin
                    sel_d   = '0;
                    ptr_d   = gid_q;
                    state_d = S_IDLE;
                    pls_d   = 1'b1;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase

        // A new start on the lane being granted keeps it pending.
        pend_d = (pend_q & ~clr) | (rx_start & VALID_MASK);

        // Flush overrides every other event of this cycle.
        if (reg_flush) begin
            pend_d  = '0;
            sel_d   = '0;
            ptr_d   = PTR_RST;
            state_d = S_IDLE;
`ifdef RX_ARB_TIMEOUT_EN
            tmr_d   = '0;
            cnt_d   = cnt_q;
            pls_d   = 1'b0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            pend_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= PTR_RST;
`ifdef RX_ARB_TIMEOUT_EN
            tmr_q   <= '0;
            cnt_q   <= '0;
            pls_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
`ifdef RX_ARB_TIMEOUT_EN
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            pls_q   <= pls_d;
`endif
        end
    end

    assign rx_sel   = sel_q;
    assign grant_id = gid_q;
    assign pend     = pend_q;
`ifdef RX_ARB_TIMEOUT_EN
    assign timeout_pls = pls_q;
    assign timeout_cnt = cnt_q;
`else
    assign timeout_pls = 1'b0;
    assign timeout_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rx_rr_arb.sv
// Testbench for rx_rr_arb: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a behavioural model.
module tb_rx_rr_arb;

    localparam int NUM     = 16;
    localparam int TIMEOUT = 8;
`ifdef RX_ARB_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif
    localparam logic [31:0] VALID = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_flush = 1'b0;
    logic [31:0] reg_mask = '0;
    logic        rx_almost_full = 1'b0;
    logic [31:0] rx_start = '0;
    logic [31:0] rx_last = '0;
    logic [31:0] rx_sel;
    logic [4:0]  grant_id;
    logic [31:0] pend;
    logic        timeout_pls;
    logic [15:0] timeout_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    rx_rr_arb #(.NUM(NUM), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_mask(reg_mask),
        .rx_almost_full(rx_almost_full), .rx_start(rx_start), .rx_last(rx_last),
        .rx_sel(rx_sel), .grant_id(grant_id), .pend(pend),
        .timeout_pls(timeout_pls), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: who holds the grant (-1 = nobody), how long, and the
    // last served PHY that the round-robin scan starts after.
    logic [31:0] m_pend = '0;
    int          m_gnt  = -1;
    int          m_gid  = 0;
    int          m_ptr  = NUM - 1;
    int          m_age  = 0;
    int          m_cnt  = 0;
    bit          m_pls  = 1'b0;

    function automatic int rr_pick(input logic [31:0] p, input logic [31:0] msk, input int after);
        for (int j = 1; j <= NUM; j++) begin
            int i;
            i = (after + j) % NUM;
            if (p[i] && !msk[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend = '0; m_gnt = -1; m_gid = 0; m_ptr = NUM - 1;
            m_age = 0; m_cnt = 0; m_pls = 1'b0;
        end else if (reg_flush) begin
            m_pend = '0; m_gnt = -1; m_ptr = NUM - 1; m_age = 0; m_pls = 1'b0;
        end else begin
            m_pls = 1'b0;
            if (m_gnt < 0) begin
                int w;
                w = rr_pick(m_pend, reg_mask, m_ptr);
                if (!rx_almost_full && w >= 0) begin
                    m_gnt = w; m_gid = w; m_age = 0; m_pend[w] = 1'b0;
                end
            end else if (rx_last[m_gnt]) begin
                m_ptr = m_gnt; m_gnt = -1;
            end else if (TEN && m_age == TIMEOUT - 1) begin
                m_ptr = m_gnt; m_gnt = -1; m_pls = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_age++;
            end
            m_pend = m_pend | (rx_start & VALID);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rx_sel", rx_sel, (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
            chk("m_grant_id", 32'(grant_id), 32'(m_gid));
            chk("m_pend", pend, m_pend);
            chk("m_timeout_pls", 32'(timeout_pls), 32'(m_pls));
            chk("m_timeout_cnt", 32'(timeout_cnt), 32'(m_cnt));
        end
    end

    // Apply start/last for one cycle; return at the negedge that shows the result.
    task automatic cyc(input logic [31:0] st, input logic [31:0] ls);
        rx_start = st;
        rx_last  = ls;
        @(negedge clk);
        rx_start = '0;
        rx_last  = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        // Reset state
        chk("rst_sel", rx_sel, 32'h0);
        chk("rst_pend", pend, 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        chk("rst_cnt", 32'(timeout_cnt), 32'h0);

        // Two requests, served 0 then 3 with an idle cycle between.
        cyc(32'h9, 0);  chk("a_pend", pend, 32'h9); chk("a_sel0", rx_sel, 32'h0);
        cyc(0, 0);      chk("a_sel1", rx_sel, 32'h1); chk("a_pend1", pend, 32'h8);
        cyc(0, 32'h1);  chk("a_idle", rx_sel, 32'h0);
        cyc(0, 0);      chk("a_sel8", rx_sel, 32'h8); chk("a_pend0", pend, 32'h0);
        chk("a_gid3", 32'(grant_id), 32'h3);
        cyc(0, 32'h8);  chk("a_done", rx_sel, 32'h0);

        // Pointer at 3: order 4, 0, 3.
        cyc(32'h19, 0); chk("b_pend", pend, 32'h19);
        cyc(0, 0);      chk("b_sel4", rx_sel, 32'h10); chk("b_gid4", 32'(grant_id), 32'h4);
        cyc(0, 32'h10);
        cyc(0, 0);      chk("b_sel0", rx_sel, 32'h1);
        cyc(0, 32'h1);
        cyc(0, 0);      chk("b_sel3", rx_sel, 32'h8); chk("b_pend0", pend, 32'h0);
        cyc(0, 32'h8);

        // Backpressure holds off the grant.
        rx_almost_full = 1'b1;
        cyc(32'h4, 0);  chk("c_pend", pend, 32'h4); chk("c_sel0", rx_sel, 32'h0);
        cyc(0, 0);      chk("c_hold", rx_sel, 32'h0);
        rx_almost_full = 1'b0;
        cyc(0, 0);      chk("c_sel4", rx_sel, 32'h4);
        cyc(0, 32'h4);

        // Mask inhibits; foreign rx_last is ignored.
        reg_mask = 32'h2;
        cyc(32'h2, 0);  chk("d_pend", pend, 32'h2);
        cyc(0, 0);      chk("d_masked", rx_sel, 32'h0);
        reg_mask = 32'h0;
        cyc(0, 0);      chk("d_sel2", rx_sel, 32'h2);
        cyc(0, 32'h20); chk("d_ignore", rx_sel, 32'h2);
        cyc(0, 32'h2);  chk("d_done", rx_sel, 32'h0);

        // Flush during PHY 6 grant; PHY 0 then wins.
        cyc(32'h40, 0);
        cyc(0, 0);      chk("e_sel6", rx_sel, 32'h40);
        cyc(32'h30, 0); chk("e_pend", pend, 32'h30);
        reg_flush = 1'b1;
        cyc(0, 0);      chk("e_fsel", rx_sel, 32'h0); chk("e_fpend", pend, 32'h0);
        reg_flush = 1'b0;
        cyc(32'h21, 0);
        cyc(0, 0);      chk("e_sel0", rx_sel, 32'h1);
        cyc(0, 32'h1);
        cyc(0, 0);      chk("e_sel5", rx_sel, 32'h20);
        cyc(0, 32'h20);

        // Long grant: watchdog abort when compiled in, otherwise held.
        cyc(32'h2, 0);
        cyc(0, 0);      chk("f_sel", rx_sel, 32'h2);
`ifdef RX_ARB_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cyc(0, 0);
            chk("f_held", rx_sel, 32'h2);
        end
        cyc(0, 0);      chk("f_abort", rx_sel, 32'h0);
        chk("f_pls", 32'(timeout_pls), 32'h1); chk("f_cnt", 32'(timeout_cnt), 32'h1);
        cyc(0, 0);      chk("f_pls0", 32'(timeout_pls), 32'h0);
`else
        repeat (20) cyc(0, 0);
        chk("f_held", rx_sel, 32'h2);
        chk("f_pls", 32'(timeout_pls), 32'h0); chk("f_cnt", 32'(timeout_cnt), 32'h0);
        cyc(0, 32'h2);  chk("f_done", rx_sel, 32'h0);
`endif

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 499) == 0);
            reg_flush      = ($urandom_range(0, 199) == 0);
            rx_almost_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) reg_mask = $urandom & $urandom;
            rx_start = $urandom & $urandom & $urandom;
            if (m_gnt >= 0 && $urandom_range(0, 5) == 0) rx_last = 32'd1 << m_gnt;
            else rx_last = $urandom & $urandom & $urandom & $urandom;
            @(negedge clk);
        end
        rst = 1'b0; reg_flush = 1'b0; rx_almost_full = 1'b0;
        rx_start = '0; rx_last = '0; reg_mask = '0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_rr_arb.md
RX_RR_ARB -- requirements
Module: rx_rr_arb

Interface
REQ-001 SHALL have parameter NUM, default 16, number of RX PHY requesters (legal range 1..32).
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum grant length in clk cycles (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port reg_flush, input, 1, clears pending requests, grant and pointer.
REQ-006 SHALL have port reg_mask, input, 32, per-PHY grant inhibit (1 = inhibit); bits >= NUM are ignored.
REQ-007 SHALL have port rx_almost_full, input, 1, downstream FIFO backpressure.
REQ-008 SHALL have port rx_start, input, 32, per-PHY one-cycle frame-start pulse.
REQ-009 SHALL have port rx_last, input, 32, per-PHY last-word pulse.
REQ-010 SHALL have port rx_sel, output, 32, registered one-hot grant.
REQ-011 SHALL have port grant_id, output, 5, registered index of the granted PHY.
REQ-012 SHALL have port pend, output, 32, registered pending-request vector.
REQ-013 SHALL have port timeout_pls, output, 1, one-cycle pulse on grant abort.
REQ-014 SHALL have port timeout_cnt, output, 16, saturating count of aborts.

Function
REQ-015 SHALL set pend[i] on rx_start[i]=1 and clear it on the cycle PHY i is granted; set wins if both occur in the same cycle.
REQ-016 SHALL implement states IDLE and GRANT.
REQ-017 In IDLE, with rx_almost_full=0 and |(pend & ~reg_mask) != 0, SHALL select the first eligible index scanning ptr+1, ptr+2, ... modulo NUM, and load rx_sel/grant_id on the next clock edge (1-cycle latency) while entering GRANT.
REQ-018 In IDLE, with rx_almost_full=1, SHALL issue no grant; pend keeps accumulating.
REQ-019 In GRANT, rx_last at the granted index SHALL clear rx_sel to 0 on the next edge, set ptr to the granted index and return to IDLE; rx_last on non-granted indices SHALL be ignored.
REQ-020 SHALL enforce at least one IDLE cycle between consecutive grants.
REQ-021 SHALL keep rx_sel zero or one-hot at all times; grant_id SHALL hold its last value while rx_sel=0.
REQ-022 SHALL ignore rx_almost_full and reg_mask changes during GRANT; an active grant runs to rx_last or timeout.
REQ-023 Bits >= NUM of rx_sel and pend SHALL stay 0.
REQ-024 reg_flush=1 SHALL on the next edge clear pend, rx_sel and the grant timer, set ptr to NUM-1 and force IDLE, taking precedence over all other events in that cycle.

Reset
REQ-025 rst SHALL set rx_sel=0, grant_id=0, pend=0, timeout_pls=0, timeout_cnt=0, ptr=NUM-1 and state IDLE; rst has priority over reg_flush.
REQ-026 rst asserted mid-GRANT SHALL abort the grant without a timeout_pls pulse.

Configuration
REQ-027 Macro RX_ARB_TIMEOUT_EN SHALL compile in the watchdog.
REQ-028 With RX_ARB_TIMEOUT_EN defined: a 16-bit timer SHALL clear on grant and increment each GRANT cycle; if it reaches TIMEOUT-1 without rx_last, rx_sel SHALL clear on the next edge, timeout_pls SHALL pulse for that cycle, timeout_cnt SHALL increment (saturating at 0xFFFF), ptr SHALL advance to the aborted index, and the state SHALL return to IDLE.
REQ-029 If rx_last for the granted index arrives in the same cycle the timer reaches TIMEOUT-1, it SHALL be a normal completion with no timeout pulse.
REQ-030 Without RX_ARB_TIMEOUT_EN: timeout_pls and timeout_cnt SHALL be constant 0, no timer SHALL exist, and a grant SHALL last until rx_last or reg_flush.

Verification
REQ-031 After reset, pulse rx_start=0x0000_0009 -> rx_sel=0x1, then (after rx_last[0] and one IDLE cycle) rx_sel=0x8; pend ends at 0.
REQ-032 With ptr=3 (after PHY 3 has completed), pend=0x0000_0019 -> grant order 4, 0, 3.
REQ-033 rx_almost_full=1 with rx_start[2] pulsed -> rx_sel stays 0 and pend=0x4; deassert rx_almost_full -> rx_sel=0x4 one cycle later.
REQ-034 reg_mask=0x2 with pend=0x2 -> no grant; clear reg_mask -> rx_sel=0x2; rx_last[5] during that grant -> no effect.
REQ-035 RX_ARB_TIMEOUT_EN, TIMEOUT=8, grant PHY 1 with no rx_last -> rx_sel clears after 8 GRANT cycles, timeout_pls=1 for one cycle, timeout_cnt=1.
REQ-036 reg_flush during a PHY 6 grant with pend=0x30 -> next cycle rx_sel=0 and pend=0; the next request on PHY 0 is granted first.
